// File: rtl/umi_pwr_pkg.sv
// Shared power-sequencing state encoding for switchable UMI domains.
package umi_pwr_pkg;

  localparam logic [2:0] PWR_OFF_ENC    = 3'd0;
  localparam logic [2:0] PWR_PWRUP_ENC  = 3'd1;
  localparam logic [2:0] PWR_SETTLE_ENC = 3'd2;
  localparam logic [2:0] PWR_ON_ENC     = 3'd3;
  localparam logic [2:0] PWR_DRAIN_ENC  = 3'd4;
  localparam logic [2:0] PWR_ISO_ENC    = 3'd5;

  typedef enum logic [2:0] {
    PWR_OFF    = PWR_OFF_ENC,
    PWR_PWRUP  = PWR_PWRUP_ENC,
    PWR_SETTLE = PWR_SETTLE_ENC,
    PWR_ON     = PWR_ON_ENC,
    PWR_DRAIN  = PWR_DRAIN_ENC,
    PWR_ISO    = PWR_ISO_ENC
  } pwr_state_e;

  function automatic int pwr_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/umi_isolate_ctrl.sv
// Power sequencer for a switchable UMI domain: drives the power switch and
// isolation clamps and gates the request channel so packets are never cut.
module umi_isolate_ctrl
  import umi_pwr_pkg::*;
#(
  parameter int CW            = 32,
  parameter int AW            = 64,
  parameter int DW            = 256,
  parameter int IDLE_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          pwr_on_req,
  output logic          pwr_ack,
  output logic          pwr_fault,
  output logic          pwr_en,
  input  logic          pwr_good,
  output logic          isolate,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready,
  input  logic          umi_resp_valid
);

  localparam int CNT_W = $clog2(pwr_max(IDLE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             fault_q, fault_d;
  logic             isolate_q, pwr_en_q, ack_q;
  logic             path_open, stall;

  // Request channel is a pure pass-through while ON and closed otherwise.
  assign path_open       = (state_q == PWR_ON);
  assign umi_out_valid   = path_open & umi_in_valid;
  assign umi_in_ready    = path_open & umi_out_ready;
  assign umi_out_cmd     = umi_in_cmd;
  assign umi_out_dstaddr = umi_in_dstaddr;
  assign umi_out_srcaddr = umi_in_srcaddr;
  assign umi_out_data    = umi_in_data;
  assign stall           = umi_out_valid & ~umi_out_ready;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Next-state, counter and fault decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      PWR_OFF: if (pwr_on_req) state_d = PWR_PWRUP;
      PWR_PWRUP: begin
        if (!pwr_on_req) state_d = PWR_OFF;
        else if (pwr_good) begin
          state_d = PWR_SETTLE;
          cnt_d   = '0;
        end
      end
      PWR_SETTLE: begin
        cnt_d = cnt_inc;
        if (!pwr_on_req) state_d = PWR_OFF;
        // Rail lost before release: re-wait for pwr_good so isolation only
        // ever drops on a good rail.
        else if (!pwr_good) state_d = PWR_PWRUP;
        else if (cnt_q == SETTLE_LAST) state_d = PWR_ON;
      end
      PWR_ON: begin
        if (!pwr_good) begin
          state_d = PWR_OFF;
          fault_d = 1'b1;
        end else if (!pwr_on_req && !stall) begin
          // A stalled beat keeps us here so valid never drops mid-transfer.
          state_d = PWR_DRAIN;
          cnt_d   = '0;
        end
      end
      PWR_DRAIN: begin
        cnt_d = umi_resp_valid ? '0 : cnt_inc;
        if (pwr_on_req) state_d = PWR_ON;
        else if (!umi_resp_valid && cnt_q == IDLE_LAST) state_d = PWR_ISO;
      end
      PWR_ISO: state_d = PWR_OFF;
      default: state_d = PWR_OFF;
    endcase
    if (!pwr_on_req) fault_d = 1'b0;
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= PWR_OFF;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      isolate_q <= 1'b1;
      pwr_en_q  <= 1'b0;
      ack_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      isolate_q <= !((state_d == PWR_ON) || (state_d == PWR_DRAIN));
      pwr_en_q  <= (state_d != PWR_OFF);
      ack_q     <= ((state_d == PWR_ON) & pwr_on_req) |
                   ((state_d == PWR_OFF) & ~pwr_on_req);
    end
  end

  assign isolate   = isolate_q;
  assign pwr_en    = pwr_en_q;
  assign pwr_ack   = ack_q;
  assign pwr_fault = fault_q;

endmodule

// File: tb/tb_umi_isolate_ctrl.sv
// Self-checking bench for umi_isolate_ctrl: sequencing latencies plus a
// packet scoreboard on the gated request channel.
module tb_umi_isolate_ctrl;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int IDLE = 8;
  localparam int SETTLE = 16;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } pkt_t;

  logic          clk = 1'b0;
  logic          nreset = 1'b1;
  logic          pwr_on_req = 1'b0;
  logic          pwr_ack, pwr_fault, pwr_en, isolate;
  logic          pwr_good = 1'b0;
  logic          umi_in_valid = 1'b0;
  logic [CW-1:0] umi_in_cmd = '0;
  logic [AW-1:0] umi_in_dstaddr = '0;
  logic [AW-1:0] umi_in_srcaddr = '0;
  logic [DW-1:0] umi_in_data = '0;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          umi_out_ready = 1'b1;
  logic          umi_resp_valid = 1'b0;

  int   checks = 0;
  int   errors = 0;
  pkt_t exp_q[$];

  umi_isolate_ctrl #(.CW(CW), .AW(AW), .DW(DW), .IDLE_CYCLES(IDLE),
                     .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .nreset(nreset), .pwr_on_req(pwr_on_req), .pwr_ack(pwr_ack),
    .pwr_fault(pwr_fault), .pwr_en(pwr_en), .pwr_good(pwr_good),
    .isolate(isolate), .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
    .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
    .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
    .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
    .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
    .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready),
    .umi_resp_valid(umi_resp_valid)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted beat must match the oldest expected packet.
  always @(negedge clk) begin
    if (nreset && umi_out_valid && umi_out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got dst=%h, expected no packet", umi_out_dstaddr);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        if (umi_out_cmd !== e.cmd || umi_out_dstaddr !== e.dst ||
            umi_out_srcaddr !== e.src || umi_out_data !== e.data) begin
          errors++;
          $display("FAIL sb_packet: got cmd=%h dst=%h src=%h, expected cmd=%h dst=%h src=%h",
                   umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, e.cmd, e.dst, e.src);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive a request beat and record it as expected at the domain side.
  task automatic send_pkt(input logic [AW-1:0] dst, input logic push);
    pkt_t p;
    p.cmd  = $urandom;
    p.dst  = dst;
    p.src  = {$urandom, $urandom};
    p.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    umi_in_cmd = p.cmd; umi_in_dstaddr = p.dst; umi_in_srcaddr = p.src; umi_in_data = p.data;
    umi_in_valid = 1'b1;
    if (push) exp_q.push_back(p);
  endtask

  // Raise the request and wait, bounded, for isolation to release.
  task automatic bring_up;
    int n = 0;
    pwr_on_req = 1'b1;
    pwr_good = 1'b1;
    while (isolate !== 1'b0 && n < 60) begin tick; n++; end
    checks++;
    if (isolate !== 1'b0) begin
      errors++;
      $display("FAIL bring_up_timeout: isolate=%b after %0d cycles, expected 0", isolate, n);
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    umi_in_valid = 1'b1;
    umi_out_ready = 1'b1;
    tick; tick;
    checks++; if (pwr_en !== 1'b0) begin errors++; $display("FAIL rst_pwr_en: got %b expected 0", pwr_en); end
    checks++; if (isolate !== 1'b1) begin errors++; $display("FAIL rst_isolate: got %b expected 1", isolate); end
    checks++; if (pwr_ack !== 1'b1) begin errors++; $display("FAIL rst_ack: got %b expected 1", pwr_ack); end
    checks++; if (pwr_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", pwr_fault); end
    checks++; if (umi_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", umi_out_valid); end
    checks++; if (umi_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", umi_in_ready); end
    umi_in_valid = 1'b0;
    nreset = 1'b1;
  endtask

  task automatic test_powerup;
    int bad = 0;
    tick;
    pwr_on_req = 1'b1;                       // cycle 0
    tick;                                    // cycle 1
    checks++;
    if (pwr_en !== 1'b1 || isolate !== 1'b1 || pwr_ack !== 1'b0) begin
      errors++; $display("FAIL pu_pwrup: en=%b iso=%b ack=%b expected 1 1 0", pwr_en, isolate, pwr_ack);
    end
    repeat (5) tick;                         // cycle 6 = k
    pwr_good = 1'b1;
    for (int i = 1; i <= SETTLE; i++) begin
      tick;
      if (isolate !== 1'b1 && bad == 0) bad = i;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pu_settle: isolate dropped at k+%0d, expected 1 through k+%0d", bad, SETTLE); end
    tick;                                    // k+SETTLE+1
    checks++;
    if (isolate !== 1'b0 || pwr_ack !== 1'b1 || umi_in_ready !== 1'b1) begin
      errors++; $display("FAIL pu_open: iso=%b ack=%b rdy=%b expected 0 1 1", isolate, pwr_ack, umi_in_ready);
    end
    send_pkt(64'h1000, 1'b1);
    #1;
    checks++;
    if (umi_out_dstaddr !== 64'h1000) begin errors++; $display("FAIL pu_dst: got %h expected 1000", umi_out_dstaddr); end
    tick;
    umi_in_valid = 1'b0;
  endtask

  task automatic test_drain_resp;
    int iso_c = -1, fall_c = -1;
    logic en_at_iso = 1'b0;
    pwr_on_req = 1'b0;                       // cycle 0
    for (int c = 1; c <= 20; c++) begin
      tick;
      umi_resp_valid = (c == 3 || c == 6);
      if (c == 1) begin
        send_pkt(64'hdead, 1'b0);
        #1;
        checks++;
        if (umi_out_valid !== 1'b0 || umi_in_ready !== 1'b0) begin
          errors++; $display("FAIL dr_closed: out_valid=%b in_ready=%b expected 0 0", umi_out_valid, umi_in_ready);
        end
        umi_in_valid = 1'b0;
      end
      if (isolate === 1'b1 && iso_c < 0) begin iso_c = c; en_at_iso = pwr_en; end
      if (pwr_en === 1'b0 && fall_c < 0) fall_c = c;
    end
    umi_resp_valid = 1'b0;
    checks++; if (iso_c != 6 + IDLE + 1) begin errors++; $display("FAIL dr_iso_cycle: got %0d expected %0d", iso_c, 6 + IDLE + 1); end
    checks++; if (en_at_iso !== 1'b1) begin errors++; $display("FAIL dr_en_at_iso: got %b expected 1", en_at_iso); end
    checks++; if (fall_c != 6 + IDLE + 2) begin errors++; $display("FAIL dr_en_fall: got %0d expected %0d", fall_c, 6 + IDLE + 2); end
    checks++; if (pwr_ack !== 1'b1) begin errors++; $display("FAIL dr_ack: got %b expected 1", pwr_ack); end
  endtask

  task automatic test_stall;
    int bad = 0;
    logic [DW-1:0] d;
    bring_up;
    umi_out_ready = 1'b0;
    send_pkt(64'h2000, 1'b1);
    d = umi_in_data;
    pwr_on_req = 1'b0;                       // cycle 0
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick;
      #1;
      if ((umi_out_valid !== 1'b1 || umi_out_dstaddr !== 64'h2000 || umi_out_data !== d ||
           umi_in_ready !== 1'b0 || isolate !== 1'b0) && bad == 0) bad = c + 1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL st_hold: beat not held stable in stall cycle %0d, expected valid=1 dst=2000", bad - 1); end
    tick;                                    // cycle 4: accept
    umi_out_ready = 1'b1;
    tick;                                    // cycle 5: DRAIN
    umi_in_valid = 1'b0;
    checks++;
    if (umi_in_ready !== 1'b0 || isolate !== 1'b0) begin
      errors++; $display("FAIL st_drain: in_ready=%b iso=%b expected 0 0", umi_in_ready, isolate);
    end
    repeat (IDLE) tick;                      // cycle 5+IDLE: ISO
    checks++;
    if (isolate !== 1'b1 || pwr_en !== 1'b1) begin
      errors++; $display("FAIL st_iso: iso=%b en=%b expected 1 1", isolate, pwr_en);
    end
    tick;
    checks++; if (pwr_en !== 1'b0) begin errors++; $display("FAIL st_off: en=%b expected 0", pwr_en); end
  endtask

  task automatic test_abort;
    int bad = 0;
    bring_up;
    pwr_on_req = 1'b0;                       // cycle 0
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 3) pwr_on_req = 1'b1;
      if ((isolate !== 1'b0 || pwr_en !== 1'b1) && bad == 0) bad = c;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ab_held: iso/en changed at cycle %0d, expected iso=0 en=1", bad); end
    checks++;
    if (umi_in_ready !== 1'b1 || pwr_ack !== 1'b1) begin
      errors++; $display("FAIL ab_on: in_ready=%b ack=%b expected 1 1", umi_in_ready, pwr_ack);
    end
    send_pkt(64'h3000, 1'b1);
    tick;
    umi_in_valid = 1'b0;
  endtask

  task automatic test_fault;
    pwr_good = 1'b0;                         // cycle 0, in ON
    tick;
    checks++;
    if (isolate !== 1'b1 || pwr_fault !== 1'b1 || pwr_en !== 1'b0) begin
      errors++; $display("FAIL ft_trip: iso=%b fault=%b en=%b expected 1 1 0", isolate, pwr_fault, pwr_en);
    end
    tick;
    checks++; if (pwr_fault !== 1'b1) begin errors++; $display("FAIL ft_sticky: got %b expected 1", pwr_fault); end
    pwr_on_req = 1'b0;
    tick;
    checks++;
    if (pwr_fault !== 1'b0 || pwr_ack !== 1'b1 || pwr_en !== 1'b0) begin
      errors++; $display("FAIL ft_clear: fault=%b ack=%b en=%b expected 0 1 0", pwr_fault, pwr_ack, pwr_en);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    pwr_good = 1'b1;
    pwr_on_req = 1'b1;
    repeat (4) tick;                         // inside SETTLE
    checks++;
    if (isolate !== 1'b1 || pwr_en !== 1'b1) begin errors++; $display("FAIL rm_pre: iso=%b en=%b expected 1 1", isolate, pwr_en); end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if (isolate !== 1'b1 || pwr_en !== 1'b0) begin errors++; $display("FAIL rm_async: iso=%b en=%b expected 1 0", isolate, pwr_en); end
    tick; tick;
    nreset = 1'b1;                           // cycle 0
    while (isolate !== 1'b0 && n < 60) begin tick; n++; end
    checks++;
    if (n != SETTLE + 2) begin errors++; $display("FAIL rm_repower: ON after %0d cycles, expected %0d", n, SETTLE + 2); end
    send_pkt(64'h4000, 1'b1);
    tick;
    umi_in_valid = 1'b0;
    tick;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drained: %0d packets outstanding, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_powerup;
    test_drain_resp;
    test_stall;
    test_abort;
    test_fault;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
